// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults, address-width helper and status struct for sync_fifo_ctrl
package fifo_pkg;
  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_WIDTH = 8;
  typedef struct packed {
    logic full;
    logic empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// sync_fifo_ctrl_if: write/read handshake, data and status bundle for sync_fifo_ctrl
// master drives wr_en/wr_data/rd_en; slave (the FIFO) drives rd_data/rd_valid/full/empty/count/overflow/underflow
// almost_full/almost_empty exist only when FIFO_ALMOST_EN is defined
interface sync_fifo_ctrl_if import fifo_pkg::*; #(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic wr_en;
  logic [WIDTH-1:0] wr_data;
  logic rd_en;
  logic [WIDTH-1:0] rd_data;
  logic rd_valid;
  logic full;
  logic empty;
  logic [addr_w(DEPTH):0] count;
  logic overflow;
  logic underflow;
`ifdef FIFO_ALMOST_EN
  logic almost_full;
  logic almost_empty;
  modport master (
    output wr_en, wr_data, rd_en,
    input rd_data, rd_valid, full, empty, count, overflow, underflow, almost_full, almost_empty
  );
  modport slave (
    input wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, count, overflow, underflow, almost_full, almost_empty
  );
`else
  modport master (
    output wr_en, wr_data, rd_en,
    input rd_data, rd_valid, full, empty, count, overflow, underflow
  );
  modport slave (
    input wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, count, overflow, underflow
  );
`endif
endinterface

// File: rtl/fifo_mem.sv
// fifo_mem: storage array, one write port, one read port with registered output, no reset
// ports: clk, we/waddr/wdata (write), re/raddr (read request), rdata (registered read data)
module fifo_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int AW = 3
) (
  input  logic clk,
  input  logic we,
  input  logic [AW-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic re,
  input  logic [AW-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: synchronous FIFO controller with pointer-derived flags and sticky error flags
// ports: clk, rst_n (async active-low), io (sync_fifo_ctrl_if.slave: write/read handshake, data, status)
// FIFO_ALMOST_EN adds registered almost_full (count>=AF_THRESH) and almost_empty (count<=AE_THRESH)
module sync_fifo_ctrl import fifo_pkg::*; #(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input logic clk,
  input logic rst_n,
  sync_fifo_ctrl_if.slave io
);
  localparam int AW = addr_w(DEPTH);
  logic [AW:0] wptr, rptr, count, count_nxt;
  logic wr_ok, rd_ok, rd_vld, ovf, unf, rd_seen;
  logic [WIDTH-1:0] mem_rdata;
  fifo_status_t st;
  assign st = '{
    full: (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]),
    empty: wptr == rptr,
    overflow: ovf,
    underflow: unf
  };
  assign wr_ok = io.wr_en && !st.full;
  assign rd_ok = io.rd_en && !st.empty;
  assign count_nxt = count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      rd_vld <= 1'b0;
      ovf <= 1'b0;
      unf <= 1'b0;
      rd_seen <= 1'b0;
    end else begin
      wptr <= wptr + (AW+1)'(wr_ok);
      rptr <= rptr + (AW+1)'(rd_ok);
      count <= count_nxt;
      rd_vld <= rd_ok;
      ovf <= ovf || (io.wr_en && st.full);
      unf <= unf || (io.rd_en && st.empty);
      rd_seen <= rd_seen || rd_ok;
    end
  fifo_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) u_mem (
    .clk(clk),
    .we(wr_ok),
    .waddr(wptr[AW-1:0]),
    .wdata(io.wr_data),
    .re(rd_ok),
    .raddr(rptr[AW-1:0]),
    .rdata(mem_rdata)
  );
  // The memory output register has no reset; masking it until the first read
  // since reset gives a cleared rd_data without adding a cycle of latency.
  assign io.rd_data = rd_seen ? mem_rdata : '0;
  assign io.rd_valid = rd_vld;
  assign io.full = st.full;
  assign io.empty = st.empty;
  assign io.count = count;
  assign io.overflow = st.overflow;
  assign io.underflow = st.underflow;
`ifdef FIFO_ALMOST_EN
  logic af, ae;
  // Registered from count_nxt so the flags line up with the registered count.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      af <= 1'b0;
      ae <= 1'b1;
    end else begin
      af <= count_nxt >= (AW+1)'(AF_THRESH);
      ae <= count_nxt <= (AW+1)'(AE_THRESH);
    end
  assign io.almost_full = af;
  assign io.almost_empty = ae;
`endif
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: scoreboard bench for sync_fifo_ctrl (DEPTH=8, WIDTH=8)
module tb_sync_fifo_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q [$];
  sync_fifo_ctrl_if #(.DEPTH(8), .WIDTH(8)) io ();
  sync_fifo_ctrl #(.DEPTH(8), .WIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .io(io)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic op(input logic we, input logic [7:0] wd, input logic re, input logic expv, input logic [7:0] expd);
    io.wr_en = we;
    io.wr_data = wd;
    io.rd_en = re;
    if (expv) exp_q.push_back(expd);
    @(posedge clk);
    #1;
    io.wr_en = 1'b0;
    io.rd_en = 1'b0;
  endtask
  always @(negedge clk)
    if (rst_n && io.rd_valid) begin
      if (exp_q.size() == 0) chk("spurious_rd_valid", 1, 0);
      else chk("rd_data", io.rd_data, exp_q.pop_front());
    end
  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, io.count, 0);
    chk({tag, "_empty"}, io.empty, 1);
    chk({tag, "_full"}, io.full, 0);
    chk({tag, "_rd_valid"}, io.rd_valid, 0);
    chk({tag, "_overflow"}, io.overflow, 0);
    chk({tag, "_underflow"}, io.underflow, 0);
    chk({tag, "_rd_data"}, io.rd_data, 0);
`ifdef FIFO_ALMOST_EN
    chk({tag, "_almost_full"}, io.almost_full, 0);
    chk({tag, "_almost_empty"}, io.almost_empty, 1);
`endif
  endtask
  initial begin
    io.wr_en = 1'b0;
    io.wr_data = '0;
    io.rd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) op(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 8'h00);
    chk("fill_full", io.full, 1);
    chk("fill_count", io.count, 8);
    chk("fill_empty", io.empty, 0);
`ifdef FIFO_ALMOST_EN
    chk("fill_almost_full", io.almost_full, 1);
    chk("fill_almost_empty", io.almost_empty, 0);
`endif
    op(1'b1, 8'hFF, 1'b0, 1'b0, 8'h00);
    chk("ovf_flag", io.overflow, 1);
    chk("ovf_count", io.count, 8);
    for (int i = 0; i < 8; i++) begin
      op(1'b0, 8'h00, 1'b1, 1'b1, 8'hA0 + 8'(i));
      chk("drain_rd_valid", io.rd_valid, 1);
    end
    chk("drain_empty", io.empty, 1);
    chk("drain_count", io.count, 0);
    op(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("idle_rd_valid", io.rd_valid, 0);
    chk("hold_rd_data", io.rd_data, 8'hA7);
    chk("ovf_sticky", io.overflow, 1);
    op(1'b1, 8'h55, 1'b1, 1'b0, 8'h00);
    chk("unf_flag", io.underflow, 1);
    chk("unf_rd_valid", io.rd_valid, 0);
    chk("unf_count", io.count, 1);
    op(1'b0, 8'h00, 1'b1, 1'b1, 8'h55);
    chk("unf_drain_count", io.count, 0);
    chk("unf_sticky", io.underflow, 1);
    for (int i = 0; i < 3; i++) op(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 20; i++) begin
      op(1'b1, 8'hC0 + 8'(i), 1'b1, 1'b1, i < 3 ? 8'hB0 + 8'(i) : 8'hC0 + 8'(i - 3));
      chk("wrap_count", io.count, 3);
    end
    for (int i = 0; i < 5; i++) op(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0, 8'h00);
    chk("refill_full", io.full, 1);
    op(1'b1, 8'hEE, 1'b1, 1'b1, 8'hC0 + 8'd17);
    chk("full_rw_count", io.count, 7);
    chk("full_rw_full", io.full, 0);
    op(1'b0, 8'h00, 1'b1, 1'b1, 8'hC0 + 8'd18);
    op(1'b0, 8'h00, 1'b1, 1'b1, 8'hC0 + 8'd19);
    chk("pre_rst_count", io.count, 5);
    op(1'b1, 8'hD5, 1'b1, 1'b1, 8'hD0);
    chk("inflight_count", io.count, 5);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk_reset_state("async_rst");
    #4;
    rst_n = 1'b1;
    repeat (4) op(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("post_rst_rd_valid", io.rd_valid, 0);
    op(1'b1, 8'h77, 1'b0, 1'b0, 8'h00);
    chk("post_rst_count", io.count, 1);
    op(1'b0, 8'h00, 1'b1, 1'b1, 8'h77);
    repeat (2) op(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
